// File: rtl/ooop_types.sv
// Shared core-wide types and sizing for the out-of-order pipeline.
// Holds the ROB sizing and the modular ring distance used by tag logic.
package ooop_types;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_W     = $clog2(ROB_DEPTH);

  // Distance from b forward to a around the tag ring.
  function automatic logic [ROB_W-1:0] ring_dist(input logic [ROB_W-1:0] a,
                                                 input logic [ROB_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/rob_age_mask.sv
// Combinational mask of the ring window [start, start+count) with wraparound.
// Recovery uses it to select every tag younger than the surviving branch.
module rob_age_mask #(
  parameter  int ROB_DEPTH = ooop_types::ROB_DEPTH,
  localparam int ROB_W     = $clog2(ROB_DEPTH)
) (
  input  logic [ROB_W-1:0]     start,
  input  logic [ROB_W-1:0]     count,
  output logic [ROB_DEPTH-1:0] mask
);

  // A tag is inside the window when its forward offset from start is below count.
  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_bit
    logic [ROB_W-1:0] offset;
    assign offset  = ROB_W'(i) - start;
    assign mask[i] = (offset < count);
  end

endmodule

// File: rtl/rob_tag_ctrl.sv
// In-order ROB tag allocator: circular allocation pointer plus a busy bit per tag.
// Commit frees single tags, branch recovery reclaims younger tags, flush clears all.
module rob_tag_ctrl #(
  parameter  int ROB_DEPTH = ooop_types::ROB_DEPTH,
  localparam int ROB_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             recover_i,
  input  logic [ROB_W-1:0] recover_tag_i,
  input  logic             alloc_i,
  output logic             tag_ok_o,
  output logic [ROB_W-1:0] rob_tag_o,
  input  logic             free_i,
  input  logic [ROB_W-1:0] free_tag_i,
  output logic [ROB_W:0]   inflight_o,
  output logic             empty_o
);

  logic [ROB_W-1:0]     ptr_q, ptr_d;
  logic [ROB_DEPTH-1:0] busy_q, busy_d;
  logic [ROB_W-1:0]     rec_start, rec_count;
  logic [ROB_DEPTH-1:0] rec_mask;
  logic [ROB_W:0]       busy_cnt;

  // The branch itself survives, so reclamation starts one past it and runs up to ptr_q.
  assign rec_start = recover_tag_i + 1'b1;
  assign rec_count = ptr_q - rec_start;

  rob_age_mask #(
    .ROB_DEPTH (ROB_DEPTH)
  ) u_age_mask (
    .start (rec_start),
    .count (rec_count),
    .mask  (rec_mask)
  );

  assign tag_ok_o   = !busy_q[ptr_q];
  assign rob_tag_o  = ptr_q;
  assign inflight_o = busy_cnt;
  assign empty_o    = (busy_q == '0);

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      busy_cnt = busy_cnt + (ROB_W+1)'(busy_q[i]);
    end
  end

  // Flush beats recover beats alloc; a commit free is layered on top of whichever wins.
  always_comb begin
    busy_d = busy_q;
    ptr_d  = ptr_q;
    if (flush_i) begin
      busy_d = '0;
      ptr_d  = '0;
    end else begin
      if (recover_i) begin
        busy_d = busy_q & ~rec_mask;
        ptr_d  = rec_start;
      end else if (alloc_i && tag_ok_o) begin
        busy_d[ptr_q] = 1'b1;
        ptr_d         = ptr_q + 1'b1;
      end
      if (free_i) begin
        busy_d[free_tag_i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
    end
  end

  // Rename must only fire when the head tag is free, and commit must only retire live tags.
  a_alloc_when_ok: assert property (@(posedge clk) disable iff (!rst_n)
    (alloc_i && !flush_i && !recover_i) |-> tag_ok_o);

  a_free_busy_tag: assert property (@(posedge clk) disable iff (!rst_n)
    (free_i && !flush_i) |-> busy_q[free_tag_i]);

endmodule

// File: tb/tb_rob_tag_ctrl.sv
// Self-checking bench for rob_tag_ctrl: directed vector table, then a randomized
// alloc/free/recover/flush stress run checked against a reference model via a scoreboard.
module tb_rob_tag_ctrl;
  import ooop_types::*;

  localparam int N = 8;

  typedef struct {
    logic       rst_n;
    logic       flush;
    logic       recover;
    logic [2:0] rtag;
    logic       alloc;
    logic       free;
    logic [2:0] ftag;
    logic       exp_ok;
    logic [2:0] exp_tag;
    logic [3:0] exp_inflight;
    logic       exp_empty;
  } vec_t;

  typedef struct {
    logic       ok;
    logic [2:0] tag;
    logic [3:0] inflight;
    logic       empty;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush_i;
  logic       recover_i;
  logic [2:0] recover_tag_i;
  logic       alloc_i;
  logic       tag_ok_o;
  logic [2:0] rob_tag_o;
  logic       free_i;
  logic [2:0] free_tag_i;
  logic [3:0] inflight_o;
  logic       empty_o;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  logic [N-1:0] busy_m;
  logic [2:0]   ptr_m;

  rob_tag_ctrl #(.ROB_DEPTH(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .recover_i     (recover_i),
    .recover_tag_i (recover_tag_i),
    .alloc_i       (alloc_i),
    .tag_ok_o      (tag_ok_o),
    .rob_tag_o     (rob_tag_o),
    .free_i        (free_i),
    .free_tag_i    (free_tag_i),
    .inflight_o    (inflight_o),
    .empty_o       (empty_o)
  );

  always #5 clk = ~clk;

  function automatic void addVec(input logic r, input logic f, input logic rc,
                                 input logic [2:0] rt, input logic a, input logic fr,
                                 input logic [2:0] ft, input logic ok,
                                 input logic [2:0] tag, input logic [3:0] inf);
    vec_t v;
    v.rst_n = r; v.flush = f; v.recover = rc; v.rtag = rt;
    v.alloc = a; v.free = fr; v.ftag = ft;
    v.exp_ok = ok; v.exp_tag = tag; v.exp_inflight = inf; v.exp_empty = (inf == 0);
    vecs.push_back(v);
  endfunction

  task automatic compareField(input string name, input int idx, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("[TB] FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, req);
    end
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL scoreboard (step %0d): got empty queue, expected an entry", idx);
      return;
    end
    e = exp_q.pop_front();
    compareField("tag_ok",   idx, int'(tag_ok_o),   int'(e.ok));
    compareField("rob_tag",  idx, int'(rob_tag_o),  int'(e.tag));
    compareField("inflight", idx, int'(inflight_o), int'(e.inflight));
    compareField("empty",    idx, int'(empty_o),    int'(e.empty));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    rst_n = v.rst_n; flush_i = v.flush; recover_i = v.recover; recover_tag_i = v.rtag;
    alloc_i = v.alloc; free_i = v.free; free_tag_i = v.ftag;
    e.ok = v.exp_ok; e.tag = v.exp_tag; e.inflight = v.exp_inflight; e.empty = v.exp_empty;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  // Reference model: per-tag age test using ring distance from the restart point.
  task automatic modelStep(input vec_t v);
    logic [N-1:0] nb;
    logic [2:0]   np, s, d;
    if (!v.rst_n || v.flush) begin
      busy_m = '0;
      ptr_m  = '0;
    end else begin
      nb = busy_m;
      np = ptr_m;
      if (v.recover) begin
        s = v.rtag + 3'd1;
        d = ring_dist(ptr_m, s);
        for (int i = 0; i < N; i++) begin
          if (ring_dist(3'(i), s) < d) nb[i] = 1'b0;
        end
        np = s;
      end else if (v.alloc && !busy_m[ptr_m]) begin
        nb[ptr_m] = 1'b1;
        np = ptr_m + 3'd1;
      end
      if (v.free) nb[v.ftag] = 1'b0;
      busy_m = nb;
      ptr_m  = np;
    end
  endtask

  function automatic logic pickBusy(output logic [2:0] tag);
    int start = $urandom_range(0, N-1);
    tag = '0;
    for (int j = 0; j < N; j++) begin
      if (busy_m[(start + j) % N]) begin
        tag = 3'((start + j) % N);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  initial begin
    vec_t v;
    logic [2:0] t;
    rst_n = 1'b0; flush_i = 1'b0; recover_i = 1'b0; recover_tag_i = '0;
    alloc_i = 1'b0; free_i = 1'b0; free_tag_i = '0;

    // Reset, with other controls active to show reset overrides them.
    addVec(0, 0, 0, 0, 1, 1, 3, 1, 0, 0);
    addVec(0, 1, 1, 2, 1, 0, 0, 1, 0, 0);
    // Fill the ring.
    for (int k = 0; k < 8; k++) addVec(1, 0, 0, 0, 1, 0, 0, (k < 7), 3'((k + 1) % 8), 4'(k + 1));
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    addVec(1, 0, 0, 0, 0, 1, 0, 1, 0, 7);
    for (int k = 1; k < 5; k++) addVec(1, 0, 0, 0, 0, 1, 3'(k), 1, 0, 4'(7 - k));
    // Reissue 0..4 across the wrap, then recover on tag 6.
    for (int k = 0; k < 5; k++) addVec(1, 0, 0, 0, 1, 0, 0, (k < 4), 3'(k + 1), 4'(4 + k));
    addVec(1, 0, 1, 6, 0, 0, 0, 1, 7, 2);
    // Flush beats alloc and free.
    addVec(1, 1, 0, 0, 1, 1, 5, 1, 0, 0);
    for (int k = 0; k < 5; k++) addVec(1, 0, 0, 0, 1, 0, 0, 1, 3'(k + 1), 4'(k + 1));
    addVec(1, 0, 0, 0, 0, 1, 0, 1, 5, 4);
    addVec(1, 0, 0, 0, 0, 1, 1, 1, 5, 3);
    // Recover + free + alloc together, then a zero-distance recover.
    addVec(1, 0, 1, 3, 1, 1, 2, 1, 4, 1);
    addVec(1, 0, 1, 3, 0, 0, 0, 1, 4, 1);
    addVec(1, 0, 0, 0, 0, 1, 3, 1, 4, 0);
    // Full ring starting at 4; recover on the youngest clears nothing, then a real one.
    for (int k = 0; k < 8; k++) addVec(1, 0, 0, 0, 1, 0, 0, (k < 7), 3'((4 + k + 1) % 8), 4'(k + 1));
    addVec(1, 0, 1, 3, 0, 0, 0, 0, 4, 8);
    addVec(1, 0, 1, 5, 0, 0, 0, 1, 6, 2);
    // Reset mid-operation.
    addVec(0, 0, 1, 4, 1, 1, 4, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);
    $display("[TB] directed table done, %0d steps", vecs.size());

    busy_m = '0;
    ptr_m  = '0;
    for (int c = 0; c < 10000; c++) begin
      v.rst_n   = 1'b1;
      v.flush   = ($urandom_range(0, 199) == 0);
      v.recover = 1'b0;
      v.rtag    = '0;
      v.free    = 1'b0;
      v.ftag    = '0;
      if (!v.flush && $urandom_range(0, 15) == 0 && pickBusy(t)) begin
        v.recover = 1'b1;
        v.rtag    = t;
      end
      v.alloc = !busy_m[ptr_m] && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0 && pickBusy(t)) begin
        v.free = 1'b1;
        v.ftag = t;
      end
      modelStep(v);
      v.exp_ok       = !busy_m[ptr_m];
      v.exp_tag      = ptr_m;
      v.exp_inflight = 4'($countones(busy_m));
      v.exp_empty    = (busy_m == '0);
      applyStimulus(v, vecs.size() + c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
